// File: rtl/wb_trace_tx_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared constants and types for the writeback trace transmitter:
//   - frame layout (byte count, header bit positions)
//   - FSM state encoding
//   - FIFO entry layout {rd, data}
//   - header byte builder
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam int FRAME_BYTES  = 5;
    localparam int HDR_SYNC_BIT = 7;
    localparam int HDR_DROP_BIT = 6;

    localparam int ENTRY_RD_W   = 5;
    localparam int ENTRY_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_LO = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [ENTRY_RD_W-1:0]   rd;
        logic [ENTRY_DATA_W-1:0] data;
    } trace_entry_t;

    // One header byte followed by the data bytes, LSB first.
    function automatic int frame_bytes(input int data_w);
        return 1 + data_w / 8;
    endfunction

    // Header: bit7 always set so the host can resync, bit6 flags lost
    // events, bit5 reserved zero, bits4:0 carry the register index.
    function automatic logic [7:0] make_header(input logic [4:0] rd,
                                               input logic       drop);
        logic [7:0] hdr;
        hdr               = {3'b000, rd};
        hdr[HDR_SYNC_BIT] = 1'b1;
        hdr[HDR_DROP_BIT] = drop;
        return hdr;
    endfunction

endpackage

// File: rtl/wb_trace_tx_if.sv
// ---------------------------------------------------------------------------
// wb_trace_tx_if
// Bundles the writeback capture inputs and the byte-serial host handshake.
//   wb_valid/wb_rd/wb_data : writeback event from the CPU
//   tx_ack                 : host acknowledge (asynchronous)
//   tx_byte/tx_strobe/tx_sof : frame byte, byte-valid request, header marker
// master = CPU/host side, slave = the transmitter.
// ---------------------------------------------------------------------------
interface wb_trace_tx_if #(
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
);
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              tx_ack;
    logic [7:0]        tx_byte;
    logic              tx_strobe;
    logic              tx_sof;

    modport master (
        output wb_valid, wb_rd, wb_data, tx_ack,
        input  tx_byte, tx_strobe, tx_sof
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, tx_ack,
        output tx_byte, tx_strobe, tx_sof
    );
endinterface

// File: rtl/wb_trace_tx_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   push/wr_data : write when not full, or when full and popping this cycle
//   pop/rd_data  : rd_data shows the head entry; pop advances it
//   full/empty/count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // Full-and-popping still accepts: the slot being read frees this edge.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_tx.sv
// ---------------------------------------------------------------------------
// wb_trace_tx
// Captures register-file writebacks into a small FIFO and sends each one to
// an external host as a 5-byte frame over an 8-bit req/ack byte port.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ena        : enables capture only; queued events still drain
//   bus        : writeback inputs, host ack in, tx byte/strobe/sof out
//   overflow   : sticky, an event was dropped since reset
//   busy       : FIFO non-empty or a frame in flight (one cycle lag)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame; pop the FIFO head into the frame register
// REQ     | raise tx_strobe with tx_byte stable, wait for ack_s high
// WAIT_LO | strobe low, wait for ack_s low, then next byte or IDLE
// ---------------------------------------------------------------------------
module wb_trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    wb_trace_tx_if.slave bus,
    output logic         overflow,
    output logic         busy
);
    localparam int ENTRY_W = RD_W + DATA_W;
    localparam int NBYTES  = frame_bytes(DATA_W);
    localparam int IDX_W   = $clog2(NBYTES);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_REQ     = REQ;
    localparam logic [1:0] ST_WAIT_LO = WAIT_LO;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic               ack_meta;
    logic               ack_s;
    logic [1:0]         state;
    logic [IDX_W-1:0]   byte_idx;
    logic [DATA_W-1:0]  frame_data;
    logic               drop_flag;
    logic [7:0]         tx_byte_q;
    logic               tx_strobe_q;
    logic               tx_sof_q;

    logic               capture;
    logic               drop;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] fifo_rd_data;

    assign capture      = bus.wb_valid & ena & (bus.wb_rd != '0);
    assign fifo_pop     = (state == ST_IDLE) & ~fifo_empty;
    assign fifo_push    = capture & (~fifo_full | fifo_pop);
    assign drop         = capture & fifo_full & ~fifo_pop;
    assign fifo_wr_data = {bus.wb_rd, bus.wb_data};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.tx_ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            frame_data  <= '0;
            drop_flag   <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_strobe_q <= 1'b0;
            tx_sof_q    <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) | (fifo_count != '0);

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tx_byte_q  <= make_header(5'(fifo_rd_data[ENTRY_W-1 -: RD_W]),
                                                  drop_flag);
                        drop_flag  <= 1'b0;
                        frame_data <= fifo_rd_data[DATA_W-1:0];
                        byte_idx   <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // First REQ cycle only raises the strobe, so tx_byte has
                    // been stable for a full cycle before the host sees it.
                    if (!tx_strobe_q) begin
                        tx_strobe_q <= 1'b1;
                        tx_sof_q    <= (byte_idx == '0);
                    end else if (ack_s) begin
                        tx_strobe_q <= 1'b0;
                        tx_sof_q    <= 1'b0;
                        state       <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!ack_s) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            byte_idx   <= byte_idx + 1'b1;
                            tx_byte_q  <= frame_data[7:0];
                            frame_data <= frame_data >> 8;
                            state      <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    tx_strobe_q <= 1'b0;
                    tx_sof_q    <= 1'b0;
                end
            endcase

            // A drop can only happen when no pop occurs, so it never races
            // with the header load clearing the flag.
            if (drop) begin
                drop_flag <= 1'b1;
                overflow  <= 1'b1;
            end
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_strobe = tx_strobe_q;
    assign bus.tx_sof    = tx_sof_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
module tb_wb_trace_tx;
    import trace_pkg::*;

    logic clk;
    logic rst_n;
    logic ena;
    logic overflow;
    logic busy;

    int n_cmp;
    int n_bad;

    wb_trace_tx_if #(.RD_W(5), .DATA_W(32)) bus ();

    wb_trace_tx #(.DEPTH(4), .DATA_W(32), .RD_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .bus      (bus),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_event(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    // Host side of one byte handshake; caller sits on a negedge.
    task automatic recv_byte(input int ack_dly, output logic [7:0] b, output logic sof);
        int t;
        t = 0;
        while (bus.tx_strobe !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        b   = bus.tx_byte;
        sof = bus.tx_sof;
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_timeout got strobe=%b want=1", bus.tx_strobe);
            b = 8'hxx;
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.tx_strobe !== 1'b1 || bus.tx_byte !== b) begin
                n_bad++;
                $display("FAIL hold_stable got strobe=%b byte=%h want strobe=1 byte=%h",
                         bus.tx_strobe, bus.tx_byte, b);
            end
        end
        bus.tx_ack = 1'b1;
        t = 0;
        while (bus.tx_strobe !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t != 3) begin
            n_bad++;
            $display("FAIL ack_to_drop got=%0d edges want=3", t);
        end
        @(negedge clk);
        bus.tx_ack = 1'b0;
    endtask

    task automatic recv_frame(input logic [7:0] hdr, input logic [31:0] data,
                              input int ack_dly, input string name);
        logic [31:0] d;
        logic [7:0]  exp_b;
        logic [7:0]  b;
        logic        s;
        d = data;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (k == 0) begin
                exp_b = hdr;
            end else begin
                exp_b = d[7:0];
                d     = d >> 8;
            end
            recv_byte(ack_dly, b, s);
            n_cmp++;
            if (b !== exp_b || s !== (k == 0)) begin
                n_bad++;
                $display("FAIL %s byte%0d got=%h sof=%b want=%h sof=%b",
                         name, k, b, s, exp_b, (k == 0));
            end
        end
    endtask

    task automatic wait_not_busy(input string name);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy got=%b want=0", name, busy);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_cmp++;
        if (bus.tx_byte !== 8'h00 || bus.tx_strobe !== 1'b0 || bus.tx_sof !== 1'b0 ||
            overflow !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s got byte=%h strobe=%b sof=%b ovf=%b busy=%b want all 0",
                     name, bus.tx_byte, bus.tx_strobe, bus.tx_sof, overflow, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_single();
        push_event(5'd5, 32'hDEADBEEF);
        recv_frame(8'h85, 32'hDEADBEEF, 1, "single");
        wait_not_busy("single_busy");
    endtask

    task automatic test_filtered();
        logic seen;
        seen = 1'b0;
        push_event(5'd0, 32'h12345678);
        ena = 1'b0;
        push_event(5'd3, 32'h33333333);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_strobe !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        ena = 1'b1;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL filtered activity got=%b want=0", seen);
        end
    endtask

    task automatic test_slow_host();
        push_event(5'd8, 32'hCAFEF00D);
        recv_frame(8'h88, 32'hCAFEF00D, 10, "slow_host");
        wait_not_busy("slow_busy");
    endtask

    task automatic test_overflow();
        logic [7:0] hdr;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'(n);
            bus.wb_data  = 32'h11111111 * n;
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got=%b want=1", overflow);
        end
        for (int n = 1; n <= 5; n++) begin
            hdr = 8'h80 | 8'(n);
            if (n == 2) hdr = hdr | 8'h40;
            recv_frame(hdr, 32'h11111111 * n, 1, "overflow");
        end
        wait_not_busy("ovf_busy");
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky got=%b want=1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic       s;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h87;
        exp_b[1] = 8'h0D;
        exp_b[2] = 8'h0C;
        push_event(5'd7, 32'h0A0B0C0D);
        for (int k = 0; k < 3; k++) begin
            recv_byte(1, b, s);
            n_cmp++;
            if (b !== exp_b[k]) begin
                n_bad++;
                $display("FAIL midrst byte%0d got=%h want=%h", k, b, exp_b[k]);
            end
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.tx_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_no_partial got strobe=%b want=0", bus.tx_strobe);
        end
        push_event(5'd9, 32'h00000001);
        recv_frame(8'h89, 32'h00000001, 1, "after_rst");
        wait_not_busy("after_rst_busy");
    endtask

    task automatic test_full_push_pop();
        int t;
        for (int n = 10; n <= 14; n++) begin
            @(negedge clk);
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'(n);
            bus.wb_data  = 32'h100 * n;
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        recv_frame(8'h8A, 32'h100 * 10, 1, "full_first");
        t = 0;
        while (dut.state !== 2'd0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (dut.fifo_count !== 3'd4) begin
            n_bad++;
            $display("FAIL full_before got count=%0d want=4", dut.fifo_count);
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd4;
        bus.wb_data  = 32'h44444444;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        n_cmp++;
        if (dut.fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pushpop got count=%0d ovf=%b want count=4 ovf=0",
                     dut.fifo_count, overflow);
        end
        for (int n = 11; n <= 14; n++) begin
            recv_frame(8'h80 | 8'(n), 32'h100 * n, 1, "full_drain");
        end
        recv_frame(8'h84, 32'h44444444, 1, "full_rd4");
        wait_not_busy("full_busy");
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ovf got=%b want=0", overflow);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.tx_ack   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_filtered();
        test_slow_host();
        test_overflow();
        test_reset_mid_frame();
        test_full_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
